imm_pack_loader: RTL and testbench
==================================

# imm_pack_loader

Instruction-stream loader that performs the inverse of the core's immediate sign-extension: it packs a 32-bit immediate into the I/S/B/J bit positions of an instruction word, merges the non-immediate fields from a template, range-checks the immediate, and writes legal words to instruction memory at consecutive word addresses. It sits between the bench/boot host and the instruction memory ahead of the pipelined core. Any legal word it writes, decoded with the same `immsrc`, returns the original immediate.

## Interface
Parameters:
- `ADDR_W`, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1  one-cycle pulse: clear address/counters and error, enter LOAD.
- `finish`  in  1  one-cycle pulse: end the load session (LOAD→DONE).
- `in_valid`  in  1  source offers a word.
- `in_ready`  out  1  loader accepts a word; the transfer occurs when `in_valid && in_ready`.
- `immsrc`  in  2  immediate format: 00 I, 01 S, 10 B, 11 J (same codes as the decoder).
- `imm`  in  32  immediate value, byte offset for B/J.
- `template`  in  32  opcode/rd/rs1/rs2/funct fields; bits occupied by the immediate are ignored.
- `mem_we`  out  1  write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  packed instruction word.
- `busy`  out  1  state is LOAD.
- `done`  out  1  state is DONE.
- `err`  out  1  sticky: at least one illegal immediate was dropped this session.
- `word_count`  out  ADDR_W+1  words written this session.

## Operation
- Packing: I `[31:20]=imm[11:0]`. S `[31:25]=imm[11:5]`, `[11:7]=imm[4:0]`. B `[31]=imm[12]`, `[7]=imm[11]`, `[30:25]=imm[10:5]`, `[11:8]=imm[4:1]`. J `[31]=imm[20]`, `[19:12]=imm[19:12]`, `[20]=imm[11]`, `[30:21]=imm[10:1]`. All remaining bits come from `template`.
- Legality rules:
  - I/S: `imm[31:11]` all equal.
  - B: `imm[31:12]` all equal and `imm[0]=0`.
  - J: `imm[31:20]` all equal and `imm[0]=0`.
- FSM with states IDLE, LOAD and DONE.
  - IDLE: `start` moves to LOAD.
  - LOAD: `finish` moves to DONE. Accepting a legal word at address 2^ADDR_W−1 also moves to DONE.
  - DONE: `start` moves to LOAD.
  - `start` in any state clears the address, `word_count` and `err` and enters LOAD. `start` takes priority over `finish` and over a same-cycle transfer; that transfer is discarded.
- `in_ready` = (state == LOAD), decoded directly from state.
- Accepted legal word: write issued with the current address, then the address and `word_count` increment.
- Accepted illegal word: consumed, no write, address unchanged, `err` set.
- Transfer coincident with `finish`: the word is processed, then the FSM enters DONE.
- Address never wraps. The full condition forces DONE, with `word_count` = 2^ADDR_W.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `word_count` = 0.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. A transfer at edge N produces `mem_we`=1 for exactly the cycle after edge N.
- Throughput is one word per cycle with no bubbles.
- `in_ready` deasserts in the cycle after the accepting edge that caused full or DONE.
- `err` and `word_count` update at the accepting edge.
- Reset asserted mid-write drops `mem_we` asynchronously. No partial state survives.

## Structure
- Shared package holds:
  - `immsrc` codes `IMM_I`/`IMM_S`/`IMM_B`/`IMM_J`, reused by the decoder and control unit.
  - FSM state encoding.
- One combinational sub-module, `imm_pack`: inputs (`immsrc`, `imm`, `template`), outputs (`word`, `legal`). The loader top holds the FSM, counters and output registers.

## Test plan
- I-type, start, then transfer: `imm`=−1 (0xFFFFFFFF), `template`=0x00000013. Required: next cycle `mem_we`=1, `mem_addr`=0, `mem_wdata`=0xFFF00013, `word_count`=1.
- B-type, `imm`=0x00000FFE with `template` 0x00000063, followed back-to-back by J-type `imm`=0xFFF00000 with `template` 0x0000006F.
  - Word 0 = 0x7E000FE3 at address 0; word 1 = 0x8000006F at address 1.
  - Both are round-trip checked through the decoder.
- Illegal immediates: S `imm`=0x800, then B `imm`=0x3. Required: no `mem_we`, `err`=1, address stays 0. A following legal word lands at address 0.
- Fill with `ADDR_W`=2 and 5 offered words. Required: 4 writes at addresses 0–3; `in_ready`=0 after the 4th accept; `done`=1; `word_count`=4; the 5th word is never accepted.
- Simultaneous events: `finish` with a transfer writes the word, then `done`. `start` with a transfer discards the word and resets the address to 0. Async `reset` during streaming returns all outputs to 0 immediately.
- Randomized: random `immsrc`/`imm`/`template`. Every written word decodes to the original `imm`, and non-immediate bits equal `template`.

Source files
------------

// File: rtl/imm_pack_loader_pkg.sv
// Shared definitions for the immediate packer/loader: immediate format codes
// (same encoding as the decoder) and the loader FSM state encoding.
package imm_pack_loader_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/imm_pack_loader_pack.sv
// Combinational packer: scatters an immediate into I/S/B/J instruction bit
// positions over a template word and flags immediates the format cannot hold.
module imm_pack
  import imm_pack_loader_pkg::*;
(
  input  logic [1:0]  immsrc,
  input  logic [31:0] imm,
  input  logic [31:0] template,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = template;
    legal = 1'b0;
    case (immsrc_e'(immsrc))
      IMM_I: begin
        word[31:20] = imm[11:0];
        legal       = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IMM_S: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
        legal       = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IMM_B: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
        legal       = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      end
      IMM_J: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
        legal       = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      end
    endcase
  end

endmodule

// File: rtl/imm_pack_loader.sv
// Loader session FSM: accepts packed instruction words and writes the legal
// ones to consecutive instruction-memory addresses, counting and flagging drops.
module imm_pack_loader
  import imm_pack_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        immsrc,
  input  logic [31:0]       imm,
  input  logic [31:0]       template,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       packed_word;
  logic              legal;
  logic              xfer, wr, last;

  imm_pack u_pack (
    .immsrc   (immsrc),
    .imm      (imm),
    .template (template),
    .word     (packed_word),
    .legal    (legal)
  );

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_LOAD);
  assign done     = (state == ST_DONE);
  assign xfer     = in_valid && in_ready;
  assign wr       = xfer && legal;
  assign last     = (addr == '1);

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_LOAD;
    end else if (state == ST_LOAD && (finish || (wr && last))) begin
      state_nx = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // start wins over a coincident transfer, so the datapath only moves when start is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      word_count <= '0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (start) begin
      addr       <= '0;
      word_count <= '0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= wr;
      if (wr) begin
        mem_addr   <= addr;
        mem_wdata  <= packed_word;
        word_count <= word_count + (ADDR_W+1)'(1);
        if (!last) begin
          addr <= addr + ADDR_W'(1);
        end
      end
      if (xfer && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_pack_loader.sv
// Directed and randomized checks of imm_pack_loader with a 4-word memory.
module tb_imm_pack_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          reset, start, finish, in_valid;
  logic          in_ready, mem_we, busy, done, err;
  logic [1:0]    immsrc;
  logic [31:0]   imm, tmpl, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   word_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  imm_pack_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .immsrc     (immsrc),
    .imm        (imm),
    .template   (tmpl),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decoder (the core's sign-extension unit)
  function automatic logic [31:0] dec(input logic [1:0] s, input logic [31:0] w);
    case (s)
      2'b00:   dec = {{20{w[31]}}, w[31:20]};
      2'b01:   dec = {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   dec = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: dec = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] immmask(input logic [1:0] s);
    case (s)
      2'b00:   immmask = 32'hFFF0_0000;
      2'b01:   immmask = 32'hFE00_0F80;
      2'b10:   immmask = 32'hFE00_0F80;
      default: immmask = 32'hFFFF_F000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] i, input logic [31:0] t);
    immsrc = s; imm = i; tmpl = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"},    64'(mem_we),   64'd0);
    chk({tag, "_busy"},  64'(busy),     64'd0);
    chk({tag, "_done"},  64'(done),     64'd0);
    chk({tag, "_err"},   64'(err),      64'd0);
    chk({tag, "_addr"},  64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_wc"},    64'(word_count), 64'd0);
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] r, iv, tv;
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    immsrc = '0; imm = '0; tmpl = '0;
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();
    chk("idle_ready", 64'(in_ready), 64'd0);

    // I-type, imm = -1
    do_start();
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_ready", 64'(in_ready), 64'd1);
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0013);
    chk("i_we", 64'(mem_we), 64'd1);
    chk("i_addr", 64'(mem_addr), 64'd0);
    chk("i_wdata", 64'(mem_wdata), 64'hFFF0_0013);
    chk("i_wc", 64'(word_count), 64'd1);
    tick();
    chk("i_we_drop", 64'(mem_we), 64'd0);

    // B then J back to back
    do_start();
    send(2'b10, 32'h0000_0FFE, 32'h0000_0063);
    chk("b_we", 64'(mem_we), 64'd1);
    chk("b_addr", 64'(mem_addr), 64'd0);
    chk("b_wdata", 64'(mem_wdata), 64'h7E00_0FE3);
    chk("b_rt", 64'(dec(2'b10, mem_wdata)), 64'h0000_0FFE);
    send(2'b11, 32'hFFF0_0000, 32'h0000_006F);
    chk("j_we", 64'(mem_we), 64'd1);
    chk("j_addr", 64'(mem_addr), 64'd1);
    chk("j_wdata", 64'(mem_wdata), 64'h8000_006F);
    chk("j_rt", 64'(dec(2'b11, mem_wdata)), 64'hFFF0_0000);
    chk("bj_wc", 64'(word_count), 64'd2);

    // Illegal immediates are dropped
    do_start();
    chk("ill_err_clr", 64'(err), 64'd0);
    send(2'b01, 32'h0000_0800, 32'h0000_0023);
    chk("ill_s_we", 64'(mem_we), 64'd0);
    chk("ill_s_err", 64'(err), 64'd1);
    send(2'b10, 32'h0000_0003, 32'h0000_0063);
    chk("ill_b_we", 64'(mem_we), 64'd0);
    chk("ill_wc", 64'(word_count), 64'd0);
    send(2'b00, 32'h0000_0005, 32'h0000_0013);
    chk("ill_next_we", 64'(mem_we), 64'd1);
    chk("ill_next_addr", 64'(mem_addr), 64'd0);
    chk("ill_next_wdata", 64'(mem_wdata), 64'h0050_0013);
    chk("ill_err_sticky", 64'(err), 64'd1);

    // Fill the 4-word memory, offer a 5th
    do_start();
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 64'(in_ready), 64'd1);
      send(2'b00, 32'(i), 32'h0000_0013);
      chk("fill_we", 64'(mem_we), 64'd1);
      chk("fill_addr", 64'(mem_addr), 64'(i));
    end
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_done", 64'(done), 64'd1);
    chk("full_wc", 64'(word_count), 64'd4);
    send(2'b00, 32'h0000_0009, 32'h0000_0013);
    chk("full_5th_we", 64'(mem_we), 64'd0);
    chk("full_5th_wc", 64'(word_count), 64'd4);

    // finish coincident with a transfer
    do_start();
    finish = 1'b1;
    send(2'b00, 32'h0000_0007, 32'h0000_0093);
    finish = 1'b0;
    chk("fin_we", 64'(mem_we), 64'd1);
    chk("fin_wdata", 64'(mem_wdata), 64'h0070_0093);
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_ready", 64'(in_ready), 64'd0);

    // start coincident with a transfer
    do_start();
    send(2'b00, 32'h0000_0001, 32'h0000_0013);
    chk("st_first_addr", 64'(mem_addr), 64'd0);
    start = 1'b1;
    send(2'b00, 32'h0000_0002, 32'h0000_0013);
    start = 1'b0;
    chk("st_discard_we", 64'(mem_we), 64'd0);
    chk("st_discard_wc", 64'(word_count), 64'd0);
    chk("st_busy", 64'(busy), 64'd1);
    send(2'b00, 32'h0000_0003, 32'h0000_0013);
    chk("st_after_addr", 64'(mem_addr), 64'd0);
    chk("st_after_wdata", 64'(mem_wdata), 64'h0030_0013);

    // Asynchronous reset during streaming
    send(2'b00, 32'h0000_0004, 32'h0000_0013);
    chk("ar_pre_we", 64'(mem_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("ar");
    tick();
    reset = 1'b0;

    // Randomized legal words, three per session
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) do_start();
      s = 2'($urandom_range(0, 3));
      r = $urandom;
      tv = $urandom;
      case (s)
        2'b00, 2'b01: iv = {{20{r[11]}}, r[11:0]};
        2'b10:        iv = {{19{r[12]}}, r[12:1], 1'b0};
        default:      iv = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      send(s, iv, tv);
      chk("rnd_we", 64'(mem_we), 64'd1);
      chk("rnd_addr", 64'(mem_addr), 64'(k % 3));
      chk("rnd_rt", 64'(dec(s, mem_wdata)), 64'(iv));
      chk("rnd_tmpl", 64'(mem_wdata & ~immmask(s)), 64'(tv & ~immmask(s)));
    end
    chk("rnd_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
